// File: rtl/riscv_imm_pkg.sv
// Shared immediate-format definitions for the RISC-V immediate encode and
// decode paths.
//   imm_sel_e   : immediate format select (I, S, B, J, U); other codes illegal
//   enc_err_e   : encode status reported with every transaction
//   fits_signed : true when value[31:lsb] are all equal (sign-extension check)
package riscv_imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_sel_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_ALIGN = 2'b10,
        ERR_SEL   = 2'b11
    } enc_err_e;

    // Encoded instruction + error flag + error code.
    localparam int ENC_PAYLOAD_W = 35;

    // An immediate fits a field whose top bit is value[lsb] when every bit from
    // lsb upward is a copy of that sign bit.
    function automatic logic fits_signed(input logic [31:0] value, input int lsb);
        logic [31:0] upper;
        upper = 32'($signed(value) >>> lsb);
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/immediate_encoder_if.sv
// Handshake bundle for immediate_encoder.
//   in_*  : request channel (template, immediate, format select) with valid/ready
//   out_* : response channel (encoded instruction and error status) with valid/ready
// slave modport is the encoder's view, master modport is the requester/consumer.
interface immediate_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_imm;
    logic [2:0]  in_imm_sel;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [1:0]  out_err_code;

    modport slave (
        input  in_valid, in_instr, in_imm, in_imm_sel, out_ready,
        output in_ready, out_valid, out_instr, out_err, out_err_code
    );

    modport master (
        output in_valid, in_instr, in_imm, in_imm_sel, out_ready,
        input  in_ready, out_valid, out_instr, out_err, out_err_code
    );

endinterface

// File: rtl/enc_skid_buffer.sv
// Generic two-entry valid/ready skid buffer.
//   clk, rst_n           : clock, async active-low reset (drops held entries)
//   in_valid/in_ready    : upstream handshake; in_ready depends only on state
//   in_data              : payload captured on acceptance
//   out_valid/out_ready  : downstream handshake
//   out_data             : oldest held payload (main register)
module enc_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;

    skid_state_e state, state_next;
    logic [W-1:0] main_q, skid_q;
    logic acc, pop;
    logic load_main, load_skid, main_from_skid;

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: if (acc) begin
                state_next = ONE;
                load_main  = 1'b1;
            end
            ONE: begin
                if (acc && pop) begin
                    load_main = 1'b1;
                end else if (acc) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: if (pop) begin
                state_next     = ONE;
                main_from_skid = 1'b1;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Data registers are reset so that outputs read zero straight after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)           main_q <= in_data;
            else if (main_from_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

endmodule

// File: rtl/immediate_encoder.sv
// Scatters a signed immediate into the fields of a 32-bit instruction
// template, with range/alignment/select checking, registered output behind a
// skid buffer and saturating transaction counters.
//   clk, rst_n       : clock, async active-low reset
//   bus (slave)      : request/response handshake bundle
//   clear_counts     : synchronous clear of both counters (wins over increment)
//   enc_count        : accepted transactions that encoded cleanly
//   err_count        : accepted transactions that reported an error
module immediate_encoder
    import riscv_imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    immediate_encoder_if.slave bus,
    input  logic               clear_counts,
    output logic [CNT_W-1:0]   enc_count,
    output logic [CNT_W-1:0]   err_count
);

    logic [31:0] encoded, enc_instr;
    logic        range_ok, align_ok, sel_ok, enc_err;
    enc_err_e    code;
    logic [ENC_PAYLOAD_W-1:0] payload_in, payload_out;
    logic        acc;

    always_comb begin
        encoded  = bus.in_instr;
        range_ok = 1'b1;
        align_ok = 1'b1;
        sel_ok   = 1'b1;
        case (bus.in_imm_sel)
            IMM_I: begin
                encoded[31:20] = bus.in_imm[11:0];
                range_ok       = fits_signed(bus.in_imm, 11);
            end
            IMM_S: begin
                encoded[31:25] = bus.in_imm[11:5];
                encoded[11:7]  = bus.in_imm[4:0];
                range_ok       = fits_signed(bus.in_imm, 11);
            end
            IMM_B: begin
                encoded[31]    = bus.in_imm[12];
                encoded[30:25] = bus.in_imm[10:5];
                encoded[11:8]  = bus.in_imm[4:1];
                encoded[7]     = bus.in_imm[11];
                range_ok       = fits_signed(bus.in_imm, 12);
                align_ok       = !bus.in_imm[0];
            end
            IMM_J: begin
                encoded[31]    = bus.in_imm[20];
                encoded[30:21] = bus.in_imm[10:1];
                encoded[20]    = bus.in_imm[11];
                encoded[19:12] = bus.in_imm[19:12];
                range_ok       = fits_signed(bus.in_imm, 20);
                align_ok       = !bus.in_imm[0];
            end
            IMM_U: begin
                encoded[31:12] = bus.in_imm[31:12];
                // Low bits of a U immediate cannot be represented at all.
                range_ok       = (bus.in_imm[11:0] == 12'h000);
            end
            default: sel_ok = 1'b0;
        endcase

        if (!sel_ok)        code = ERR_SEL;
        else if (!align_ok) code = ERR_ALIGN;
        else if (!range_ok) code = ERR_RANGE;
        else                code = ERR_NONE;

        enc_err   = (code != ERR_NONE);
        // A failed encode hands the template back untouched.
        enc_instr = enc_err ? bus.in_instr : encoded;
    end

    assign payload_in = {enc_instr, enc_err, code};

    enc_skid_buffer #(.W(ENC_PAYLOAD_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (payload_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (payload_out)
    );

    assign bus.out_instr    = payload_out[34:3];
    assign bus.out_err      = payload_out[2];
    assign bus.out_err_code = payload_out[1:0];

    assign acc = bus.in_valid && bus.in_ready;

    // Counters follow acceptance, not delivery, so they reflect what entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (clear_counts) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (acc) begin
            if (enc_err) begin
                if (err_count != '1) err_count <= err_count + CNT_W'(1);
            end else begin
                if (enc_count != '1) enc_count <= enc_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_immediate_encoder.sv
// Self-checking bench for immediate_encoder: a table of hand-encoded vectors,
// then streaming, backpressure, counter clear/saturation and reset sequences.
module tb_immediate_encoder;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_counts = 1'b0;
    logic [CNT_W-1:0] enc_count, err_count;

    immediate_encoder_if bus();

    immediate_encoder #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clear_counts (clear_counts),
        .enc_count    (enc_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic [31:0] exp_instr;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int passes = 0;
    int exp_enc = 0;
    int exp_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int sat_inc(input int v);
        return (v >= (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] imm,
                         input logic [2:0] sel);
        bus.in_valid   = v;
        bus.in_instr   = instr;
        bus.in_imm     = imm;
        bus.in_imm_sel = sel;
    endtask

    initial begin
        vecs.push_back('{"i_neg1",     32'h00000093, 32'hFFFFFFFF, 3'b000, 32'hFFF00093, 1'b0, 2'b00});
        vecs.push_back('{"s_pos",      32'h00002023, 32'h00000123, 3'b001, 32'h120021A3, 1'b0, 2'b00});
        vecs.push_back('{"s_min",      32'h00002023, 32'hFFFFF800, 3'b001, 32'h80002023, 1'b0, 2'b00});
        vecs.push_back('{"b_neg4",     32'h00000063, 32'hFFFFFFFC, 3'b010, 32'hFE000EE3, 1'b0, 2'b00});
        vecs.push_back('{"b_max",      32'h00000063, 32'h00000FFE, 3'b010, 32'h7E000FE3, 1'b0, 2'b00});
        vecs.push_back('{"j_zero",     32'hFFFFF0EF, 32'h00000000, 3'b011, 32'h000000EF, 1'b0, 2'b00});
        vecs.push_back('{"j_bit11",    32'h0000006F, 32'h00000800, 3'b011, 32'h0010006F, 1'b0, 2'b00});
        vecs.push_back('{"j_min",      32'h0000006F, 32'hFFF00000, 3'b011, 32'h8000006F, 1'b0, 2'b00});
        vecs.push_back('{"u_ok",       32'h00000037, 32'h12345000, 3'b100, 32'h12345037, 1'b0, 2'b00});
        vecs.push_back('{"j_misalign", 32'h0000006F, 32'h00000003, 3'b011, 32'h0000006F, 1'b1, 2'b10});
        vecs.push_back('{"i_range",    32'h00000093, 32'h00000800, 3'b000, 32'h00000093, 1'b1, 2'b01});
        vecs.push_back('{"u_range",    32'h00000037, 32'h12345001, 3'b100, 32'h00000037, 1'b1, 2'b01});
        vecs.push_back('{"sel_111",    32'h00000013, 32'h00000000, 3'b111, 32'h00000013, 1'b1, 2'b11});
        vecs.push_back('{"b_prio",     32'h00000063, 32'h00001001, 3'b010, 32'h00000063, 1'b1, 2'b10});

        drive(1'b0, 32'h0, 32'h0, 3'b000);
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'h0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        check("rst_err_code", 32'(bus.out_err_code), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one transaction at a time, output visible the cycle after accept.
        foreach (vecs[k]) begin
            @(negedge clk);
            drive(1'b1, vecs[k].instr, vecs[k].imm, vecs[k].sel);
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (vecs[k].exp_err) exp_errs = sat_inc(exp_errs);
            else                 exp_enc  = sat_inc(exp_enc);
            check({vecs[k].name, "_valid"}, 32'(bus.out_valid), 32'd1);
            check({vecs[k].name, "_instr"}, bus.out_instr, vecs[k].exp_instr);
            check({vecs[k].name, "_err"}, 32'(bus.out_err), 32'(vecs[k].exp_err));
            check({vecs[k].name, "_code"}, 32'(bus.out_err_code), 32'(vecs[k].exp_code));
            check({vecs[k].name, "_enc_cnt"}, 32'(enc_count), 32'(exp_enc));
            check({vecs[k].name, "_err_cnt"}, 32'(err_count), 32'(exp_errs));
        end

        // Clear, then 20 back-to-back good transactions: full throughput, saturation.
        @(negedge clk);
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        check("clear_enc", 32'(enc_count), 32'd0);
        check("clear_err", 32'(err_count), 32'd0);
        exp_enc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("stream_instr", bus.out_instr, ((32'(i) - 1) << 20) | 32'h13);
                check("stream_in_ready", 32'(bus.in_ready), 32'd1);
            end
            drive(1'b1, 32'h00000013, 32'(i), 3'b000);
            exp_enc = sat_inc(exp_enc);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("stream_last", bus.out_instr, (32'd19 << 20) | 32'h13);
        check("sat_enc_count", 32'(enc_count), 32'(exp_enc));
        check("sat_enc_15", 32'(enc_count), 32'd15);
        @(negedge clk);
        check("stream_drained", 32'(bus.out_valid), 32'd0);

        // clear_counts coincident with an accept leaves zero.
        clear_counts = 1'b1;
        drive(1'b1, 32'h00000013, 32'h5, 3'b000);
        @(negedge clk);
        clear_counts = 1'b0;
        bus.in_valid = 1'b0;
        check("clear_wins", 32'(enc_count), 32'd0);
        @(negedge clk);

        // Backpressure: A and B accepted, C held off until the skid drains.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00000013, 32'h0A, 3'b000);
        @(negedge clk);
        check("bp_ready_after_a", 32'(bus.in_ready), 32'd1);
        check("bp_a_visible", bus.out_instr, 32'h00A00013);
        drive(1'b1, 32'h00000013, 32'h0B, 3'b000);
        @(negedge clk);
        check("bp_ready_after_b", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 32'h00000013, 32'h0C, 3'b000);
        @(negedge clk);
        check("bp_ready_held", 32'(bus.in_ready), 32'd0);
        check("bp_a_stable", bus.out_instr, 32'h00A00013);
        check("bp_cnt_two", 32'(enc_count), 32'd2);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_b", bus.out_instr, 32'h00B00013);
        check("bp_ready_again", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_out_c", bus.out_instr, 32'h00C00013);
        check("bp_c_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("bp_no_dup", 32'(bus.out_valid), 32'd0);
        check("bp_cnt_three", 32'(enc_count), 32'd3);

        // Reset while holding two entries.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00000013, 32'h0D, 3'b000);
        @(negedge clk);
        drive(1'b1, 32'h00000013, 32'h0E, 3'b000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pre_rst_full", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_instr", bus.out_instr, 32'h0);
        check("arst_enc_count", 32'(enc_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_empty", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/immediate_encoder.md
# immediate_encoder

- Inverse of the immediate decode path: takes a 32-bit instruction template, a signed immediate value and an immediate type, and scatters the immediate bits into the template's encoding fields.
- Checks range and alignment, and flags errors.
- Output is registered behind a valid/ready skid buffer and carries per-transaction error status, plus saturating statistics counters.
- Sits in front of the instruction path for the debug program buffer and the boot-time instruction injector.

## Interface
- CNT_W, 16, width of each statistics counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  encoder can accept input
- in_instr  in  32  template; immediate-field bits are overwritten, all others pass through
- in_imm  in  32  two's-complement immediate; for U-type, the full byte value with low 12 bits zero
- in_imm_sel  in  3  000 I, 001 S, 010 B, 011 J, 100 U; others illegal
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts output
- out_instr  out  32  encoded instruction
- out_err  out  1  transaction failed encoding
- out_err_code  out  2  00 ok, 01 range, 10 misaligned, 11 illegal sel
- clear_counts  in  1  synchronous clear of both counters
- enc_count  out  CNT_W  accepted transactions with out_err=0
- err_count  out  CNT_W  accepted transactions with out_err=1

## Operation
- Field insertion; template bits not listed are preserved:
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - U: [31:12]=imm[31:12]
- Range rules:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal.
  - J: imm[31:20] all equal.
  - U: imm[11:0]==0; a violation reports code 01.
- Alignment: B and J require imm[0]==0.
- Error priority: illegal sel (11) > misaligned (10) > range (01).
- On any error, out_instr equals in_instr unmodified and out_err=1.
- Skid buffer state machine; in_ready = (state != TWO):
  - EMPTY: nothing held.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Transitions, where acc = in_valid&&in_ready and pop = out_valid&&out_ready:
  - EMPTY→ONE on acc.
  - ONE→TWO on acc&&!pop.
  - ONE→EMPTY on pop&&!acc.
  - ONE stays on acc&&pop.
  - TWO→ONE on pop; the skid register moves to main.
- Transactions leave in acceptance order. None are dropped or duplicated.
- Counters:
  - Update on acc, not on pop.
  - Saturate at 2^CNT_W-1.
  - clear_counts in the same cycle as an increment wins, leaving the counter at 0.

## Timing
- Latency: accept at edge N → out_valid=1 after edge N, i.e. visible in cycle N+1.
- Sustained throughput: 1 transaction/cycle while out_ready=1.
- out_instr/out_err/out_err_code are stable while out_valid && !out_ready.
- in_ready is a registered function of state and does not depend combinationally on out_ready.
- Reset values:
  - out_valid=0, out_instr=0, out_err=0, out_err_code=00, counters=0.
  - State EMPTY, so in_ready=1.
- Reset asserted mid-operation discards held transactions immediately, asynchronously, with the values above.
- Counters change on the edge of acceptance. Counts are visible in the next cycle.

## Structure
- Shared package riscv_imm_pkg holds:
  - typedef enum imm_sel_e {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U}, 3 bits, codes as above. immediate_generator uses the same enum.
  - typedef enum enc_err_e {ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_SEL}.
- Encode and check logic is combinational in this module.
- One sub-module, enc_skid_buffer: generic two-entry valid/ready skid buffer, parameterized on payload width; payload here is 35 bits = instr + err + code.

## Test plan
- I-type: in_instr=32'h00000093, in_imm=32'hFFFFFFFF, sel 000.
  - Response: next cycle out_instr=32'hFFF00093, out_err=0, enc_count=1.
- B-type: in_instr=32'h00000063, in_imm=32'hFFFFFFFC, sel 010 → out_instr=32'hFE000EE3.
- J-type: in_imm=32'h00000000, out_ready=1 → out_instr=template with zero J fields, no error.
- Errors:
  - Misaligned: sel 011, imm=32'h00000003 → code 10, out_instr=in_instr.
  - Range: sel 000, imm=32'h00000800 → code 01.
  - U range: sel 100, imm=32'h12345001 → code 01.
  - Illegal sel: sel 111 → code 11.
  - err_count=4 after all four.
- Backpressure: out_ready=0, in_valid=1 with values A,B,C.
  - Exactly A,B are accepted; in_ready=0 from the cycle after B.
  - Raise out_ready: outputs A,B,C in order, each exactly once.
- Counters and reset:
  - With CNT_W=4, 20 good transactions → enc_count=15.
  - clear_counts coincident with an accept → 0.
  - rst_n low while in state TWO → out_valid=0, in_ready=1 immediately, held data lost.
